// File: rtl/mips_cpu_pkg.sv
// mips_cpu_pkg: shared next-PC select encoding and PC-unit state types
package mips_cpu_pkg;
    typedef enum logic [1:0] {
        INCREMENT = 2'b00,
        BRANCH    = 2'b01,
        JUMP      = 2'b10,
        JR        = 2'b11
    } pc_sel_t;
    typedef enum logic [1:0] {
        RUN    = 2'b00,
        DELAY  = 2'b01,
        HALTED = 2'b10
    } pc_state_t;
endpackage

// File: rtl/mips_cpu_pc_unit_if.sv
// mips_cpu_pc_unit_if: decoder/ALU controls in, fetch-side PC status out
interface mips_cpu_pc_unit_if #(parameter int ADDR_W = 32);
    import mips_cpu_pkg::*;
    logic              stall;
    pc_sel_t           pc_sel;
    logic              is_true;
    logic [ADDR_W-1:0] extended_imm;
    logic [25:0]       j_addr;
    logic [ADDR_W-1:0] reg_data_a;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] link_pc;
    logic              delay_slot;
    logic              active;
    logic              addr_err;
    modport master(
        output stall, pc_sel, is_true, extended_imm, j_addr, reg_data_a,
        input  pc, link_pc, delay_slot, active, addr_err
    );
    modport slave(
        input  stall, pc_sel, is_true, extended_imm, j_addr, reg_data_a,
        output pc, link_pc, delay_slot, active, addr_err
    );
endinterface

// File: rtl/mips_cpu_pc_target.sv
// mips_cpu_pc_target: combinational redirect target and JR alignment check
module mips_cpu_pc_target
    import mips_cpu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] pc,
    input  pc_sel_t           pc_sel,
    input  logic [ADDR_W-1:0] extended_imm,
    input  logic [25:0]       j_addr,
    input  logic [ADDR_W-1:0] reg_data_a,
    output logic [ADDR_W-1:0] target,
    output logic              misaligned
);
    logic [ADDR_W-1:0] pc4;
    always_comb begin
        pc4 = pc + ADDR_W'(4);
        target = pc_sel == BRANCH ? pc4 + (extended_imm << 2) :
                 pc_sel == JUMP   ? (pc4 & ~ADDR_W'(28'hFFF_FFFF)) | ADDR_W'({j_addr, 2'b00}) :
                 pc_sel == JR     ? reg_data_a : pc4;
        misaligned = pc_sel == JR && reg_data_a[1:0] != 2'b00;
    end
endmodule

// File: rtl/mips_cpu_pc_unit.sv
// mips_cpu_pc_unit: registered PC with one branch-delay slot, stall, halt and JR alignment error
module mips_cpu_pc_unit
    import mips_cpu_pkg::*;
#(
    parameter int          ADDR_W       = 32,
    parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000,
    parameter logic [31:0] HALT_ADDR    = 32'h0
) (
    input logic                clk,
    input logic                reset,
    mips_cpu_pc_unit_if.slave  bus
);
    pc_state_t         state, state_n;
    logic [ADDR_W-1:0] pc, pc_n, pend, pend_n, target;
    logic              addr_err, err_n, misaligned, taken;
    mips_cpu_pc_target #(.ADDR_W(ADDR_W)) u_target (
        .pc           (pc),
        .pc_sel       (bus.pc_sel),
        .extended_imm (bus.extended_imm),
        .j_addr       (bus.j_addr),
        .reg_data_a   (bus.reg_data_a),
        .target       (target),
        .misaligned   (misaligned)
    );
    assign taken = (bus.pc_sel == BRANCH && bus.is_true) || bus.pc_sel == JUMP || bus.pc_sel == JR;
    // a flagged error can only belong to the redirect now pending, since any error ends in HALTED
    always_comb begin
        state_n = state;
        pc_n    = pc;
        pend_n  = pend;
        err_n   = addr_err;
        if (!bus.stall) begin
            case (state)
                RUN: begin
                    pc_n    = pc + ADDR_W'(4);
                    state_n = taken ? DELAY : RUN;
                    pend_n  = taken ? target : pend;
                    err_n   = addr_err | (taken & misaligned);
                end
                DELAY: begin
                    pc_n    = pend;
                    state_n = (pend == ADDR_W'(HALT_ADDR) || addr_err) ? HALTED : RUN;
                end
                default: ;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= RUN;
            pc       <= ADDR_W'(RESET_VECTOR);
            pend     <= '0;
            addr_err <= 1'b0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            pend     <= pend_n;
            addr_err <= err_n;
        end
    end
    assign bus.pc         = pc;
    assign bus.link_pc    = pc + ADDR_W'(8);
    assign bus.delay_slot = state == DELAY;
    assign bus.active     = state != HALTED;
    assign bus.addr_err   = addr_err;
endmodule

// File: tb/tb_mips_cpu_pc_unit.sv
// tb_mips_cpu_pc_unit: directed stimulus with a cycle-tagged scoreboard checked by a negedge monitor
module tb_mips_cpu_pc_unit;
    import mips_cpu_pkg::*;
    typedef struct {
        string       name;
        int          cyc;
        logic [31:0] pc;
        logic        ds;
        logic        act;
        logic        err;
    } exp_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int cyc = 0;
    int checks = 0;
    int errors = 0;
    exp_t q[$];
    exp_t e;
    logic [31:0] ep;
    mips_cpu_pc_unit_if #(.ADDR_W(32)) bus ();
    mips_cpu_pc_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            checks++;
            if ({bus.pc, bus.link_pc, bus.delay_slot, bus.active, bus.addr_err} !==
                {e.pc, e.pc + 32'd8, e.ds, e.act, e.err}) begin
                errors++;
                $display("FAIL %s: got pc=%h link=%h ds=%b act=%b err=%b, want pc=%h link=%h ds=%b act=%b err=%b",
                         e.name, bus.pc, bus.link_pc, bus.delay_slot, bus.active, bus.addr_err,
                         e.pc, e.pc + 32'd8, e.ds, e.act, e.err);
            end
        end
    end
    task automatic push(input string name, input int due, input logic [31:0] epc,
                        input logic eds, input logic eact, input logic eerr);
        exp_t x;
        x.name = name; x.cyc = due; x.pc = epc; x.ds = eds; x.act = eact; x.err = eerr;
        q.push_back(x);
    endtask
    task automatic step(input pc_sel_t sel, input logic tr, input logic [31:0] imm,
                        input logic [25:0] ja, input logic [31:0] ra, input logic st,
                        input string name, input logic [31:0] epc,
                        input logic eds, input logic eact, input logic eerr);
        bus.pc_sel = sel; bus.is_true = tr; bus.extended_imm = imm;
        bus.j_addr = ja; bus.reg_data_a = ra; bus.stall = st;
        push(name, cyc + 1, epc, eds, eact, eerr);
        @(posedge clk);
        #1;
    endtask
    task automatic incs(input int n, input string name);
        for (int i = 0; i < n; i++) begin
            ep = ep + 32'd4;
            step(INCREMENT, 1'b0, 32'h0, 26'h0, 32'h0, 1'b0, name, ep, 1'b0, 1'b1, 1'b0);
        end
    endtask
    initial begin
        bus.stall = 1'b0; bus.pc_sel = INCREMENT; bus.is_true = 1'b0;
        bus.extended_imm = '0; bus.j_addr = '0; bus.reg_data_a = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        push("reset_state", cyc, 32'hBFC0_0000, 1'b0, 1'b1, 1'b0);
        reset = 1'b0;
        ep = 32'hBFC0_0000;
        incs(4, "increment");
        step(BRANCH, 1'b1, 32'hFFFF_FFFE, 26'h0, 32'h0, 1'b0, "branch_slot", 32'hBFC0_0014, 1'b1, 1'b1, 1'b0);
        step(BRANCH, 1'b1, 32'h0000_0040, 26'h0, 32'h0, 1'b0, "branch_target", 32'hBFC0_000C, 1'b0, 1'b1, 1'b0);
        ep = 32'hBFC0_000C;
        incs(5, "after_branch");
        step(BRANCH, 1'b0, 32'h0000_0040, 26'h0, 32'h0, 1'b0, "branch_not_taken", 32'hBFC0_0024, 1'b0, 1'b1, 1'b0);
        ep = 32'hBFC0_0024;
        incs(3, "after_not_taken");
        push("link_pc", cyc, 32'hBFC0_0030, 1'b0, 1'b1, 1'b0);
        step(JUMP, 1'b0, 32'h0, 26'h000_0100, 32'h0, 1'b0, "jump_slot", 32'hBFC0_0034, 1'b1, 1'b1, 1'b0);
        step(INCREMENT, 1'b0, 32'h0, 26'h0, 32'h0, 1'b0, "jump_target", 32'hB000_0400, 1'b0, 1'b1, 1'b0);
        step(BRANCH, 1'b1, 32'h0000_0004, 26'h0, 32'h0, 1'b0, "stall_slot", 32'hB000_0404, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++)
            step(JUMP, 1'b1, 32'h0, 26'h3FF_FFFF, 32'h0, 1'b1, "stall_hold", 32'hB000_0404, 1'b1, 1'b1, 1'b0);
        step(INCREMENT, 1'b0, 32'h0, 26'h0, 32'h0, 1'b0, "stall_release", 32'hB000_0414, 1'b0, 1'b1, 1'b0);
        step(JR, 1'b0, 32'h0, 26'h0, 32'h0000_0002, 1'b1, "stall_run", 32'hB000_0414, 1'b0, 1'b1, 1'b0);
        step(JUMP, 1'b0, 32'h0, 26'h000_0003, 32'h0, 1'b0, "pre_reset_slot", 32'hB000_0418, 1'b1, 1'b1, 1'b0);
        reset = 1'b1;
        step(INCREMENT, 1'b0, 32'h0, 26'h0, 32'h0, 1'b1, "reset_in_delay", 32'hBFC0_0000, 1'b0, 1'b1, 1'b0);
        reset = 1'b0;
        step(INCREMENT, 1'b0, 32'h0, 26'h0, 32'h0, 1'b0, "no_redirect_after_reset", 32'hBFC0_0004, 1'b0, 1'b1, 1'b0);
        step(JR, 1'b0, 32'h0, 26'h0, 32'h0, 1'b0, "jr_halt_slot", 32'hBFC0_0008, 1'b1, 1'b1, 1'b0);
        step(INCREMENT, 1'b0, 32'h0, 26'h0, 32'h0, 1'b0, "jr_halted", 32'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++)
            step(pc_sel_t'(i % 4), i[0], 32'h10, 26'h55, $urandom, i[1], "halt_hold", 32'h0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        step(INCREMENT, 1'b0, 32'h0, 26'h0, 32'h0, 1'b0, "reset_from_halt", 32'hBFC0_0000, 1'b0, 1'b1, 1'b0);
        reset = 1'b0;
        step(JR, 1'b0, 32'h0, 26'h0, 32'h0000_1002, 1'b0, "misalign_flag", 32'hBFC0_0004, 1'b1, 1'b1, 1'b1);
        step(INCREMENT, 1'b0, 32'h0, 26'h0, 32'h0, 1'b0, "misalign_halt", 32'h0000_1002, 1'b0, 1'b0, 1'b1);
        step(JUMP, 1'b1, 32'h0, 26'h1, 32'h0, 1'b0, "misalign_sticky", 32'h0000_1002, 1'b0, 1'b0, 1'b1);
        reset = 1'b1;
        step(INCREMENT, 1'b0, 32'h0, 26'h0, 32'h0, 1'b0, "reset_clears_err", 32'hBFC0_0000, 1'b0, 1'b1, 1'b0);
        reset = 1'b0;
        step(JR, 1'b0, 32'h0, 26'h0, 32'hFFFF_FFFC, 1'b0, "wrap_slot", 32'hBFC0_0004, 1'b1, 1'b1, 1'b0);
        step(INCREMENT, 1'b0, 32'h0, 26'h0, 32'h0, 1'b0, "wrap_top", 32'hFFFF_FFFC, 1'b0, 1'b1, 1'b0);
        step(INCREMENT, 1'b0, 32'h0, 26'h0, 32'h0, 1'b0, "wrap_zero", 32'h0, 1'b0, 1'b1, 1'b0);
        step(INCREMENT, 1'b0, 32'h0, 26'h0, 32'h0, 1'b0, "wrap_continue", 32'h4, 1'b0, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
